// File: rtl/afe_pkg.sv
// Purpose : shared defaults and capture-state type for the AFE threshold comparator.
// Latency : n/a (constants and types only).
// Backpressure: n/a.
package afe_pkg;

  localparam int         DW_DEF      = 8;
  localparam int         CW_DEF      = 10;
  localparam logic [7:0] VIL_RST_DEF = 8'h55;
  localparam logic [7:0] VIH_RST_DEF = 8'hAA;

  // PWM capture FSM: IDLE waits for the first rise, HIGH measures, LOW waits for the next rise.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_t;

endpackage

// File: rtl/pwm_duty_cap.sv
// Purpose : measure the high time of an asynchronous PWM and turn it into a DW-bit threshold.
// Latency : threshold updates 3 clocks after the PWM falling edge (2-flop sync + capture).
// Backpressure: none; free-running, one capture per complete high pulse.
//
// Ports:
//   clk   - sample clock, rising edge
//   rst_n - synchronous active-low reset
//   pwm   - asynchronous PWM input
//   thr   - captured threshold, top DW bits of the high-time count
module pwm_duty_cap
  import afe_pkg::*;
#(
  parameter int          DW      = DW_DEF,
  parameter int          CW      = CW_DEF,
  parameter logic [DW-1:0] THR_RST = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pwm,
  output logic [DW-1:0] thr
);

  logic          sync1;
  logic          sync2;
  logic          sync_d;
  logic [2:0]    warm;
  logic          rise;
  logic          fall;
  cap_state_t    state;
  logic [CW-1:0] cnt;

  // Edges are only trusted once sync2 and sync_d both hold real input samples.
  // Without this, a PWM that is already high when reset releases would look
  // like a fresh rise and a partial pulse would be captured as a threshold.
  assign rise = warm[2] &  sync2 & ~sync_d;
  assign fall = warm[2] & ~sync2 &  sync_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
      warm   <= '0;
      state  <= IDLE;
      cnt    <= '0;
      thr    <= THR_RST;
    end else begin
      sync1  <= pwm;
      sync2  <= sync1;
      sync_d <= sync2;
      warm   <= {warm[1:0], 1'b1};

      case (state)
        IDLE: begin
          if (rise) begin
            state <= HIGH;
            cnt   <= CW'(1);
          end
        end
        HIGH: begin
          if (fall) begin
            state <= LOW;
            thr   <= cnt[CW-1 -: DW];
          end else if (sync2 && (cnt != '1)) begin
            // Saturate rather than wrap so over-long pulses read as full scale.
            cnt <= cnt + CW'(1);
          end
        end
        LOW: begin
          if (rise) begin
            state <= HIGH;
            cnt   <= CW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/afe_thresh_cmp.sv
// Purpose : per-channel window comparator against PWM-programmed low/high thresholds.
// Latency : 1 clock from smpl_vld to out_vld; thresholds 3 clocks after PWM fall.
// Backpressure: none; results hold while smpl_vld is low.
//
// Ports:
//   smpl_clk         - single clock, rising edge
//   rst_n            - synchronous active-low reset
//   VIL_PWM, VIH_PWM - asynchronous PWMs whose duty sets VIL / VIH
//   smpl_vld, smpl   - sample strobe and NCH packed DW-bit samples (ch i at [i*DW +: DW])
//   chL, chH         - registered per-channel results: smpl >= VIL, smpl > VIH
//   out_vld          - smpl_vld delayed one clock
//   VIL, VIH         - current thresholds
//   thr_err          - registered VIL > VIH flag (informational, compares still run)
module afe_thresh_cmp
  import afe_pkg::*;
#(
  parameter int            NCH     = 5,
  parameter int            DW      = DW_DEF,
  parameter int            CW      = CW_DEF,
  parameter logic [DW-1:0] VIL_RST = VIL_RST_DEF,
  parameter logic [DW-1:0] VIH_RST = VIH_RST_DEF
) (
  input  logic              smpl_clk,
  input  logic              rst_n,
  input  logic              VIL_PWM,
  input  logic              VIH_PWM,
  input  logic              smpl_vld,
  input  logic [NCH*DW-1:0] smpl,
  output logic [NCH-1:0]    chL,
  output logic [NCH-1:0]    chH,
  output logic              out_vld,
  output logic [DW-1:0]     VIL,
  output logic [DW-1:0]     VIH,
  output logic              thr_err
);

  logic [NCH-1:0] lo_cmp;
  logic [NCH-1:0] hi_cmp;

  pwm_duty_cap #(
    .DW      (DW),
    .CW      (CW),
    .THR_RST (VIL_RST)
  ) u_vil (
    .clk   (smpl_clk),
    .rst_n (rst_n),
    .pwm   (VIL_PWM),
    .thr   (VIL)
  );

  pwm_duty_cap #(
    .DW      (DW),
    .CW      (CW),
    .THR_RST (VIH_RST)
  ) u_vih (
    .clk   (smpl_clk),
    .rst_n (rst_n),
    .pwm   (VIH_PWM),
    .thr   (VIH)
  );

  // Compares use the registered thresholds, so a capture landing on the same
  // edge as a sample is seen only by the following sample.
  always_comb begin
    lo_cmp = '0;
    hi_cmp = '0;
    for (int i = 0; i < NCH; i++) begin
      lo_cmp[i] = (smpl[i*DW +: DW] >= VIL);
      hi_cmp[i] = (smpl[i*DW +: DW] >  VIH);
    end
  end

  always_ff @(posedge smpl_clk) begin
    if (!rst_n) begin
      chL     <= '0;
      chH     <= '0;
      out_vld <= 1'b0;
      thr_err <= 1'b0;
    end else begin
      out_vld <= smpl_vld;
      thr_err <= (VIL > VIH);
      if (smpl_vld) begin
        chL <= lo_cmp;
        chH <= hi_cmp;
      end
    end
  end

endmodule

// File: tb/tb_afe_thresh_cmp.sv
// Purpose : directed self-checking bench for afe_thresh_cmp.
// Latency : n/a.
// Backpressure: n/a.
module tb_afe_thresh_cmp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vil_pwm;
  logic        vih_pwm;
  logic        smpl_vld;
  logic [39:0] smpl;
  logic [4:0]  chL;
  logic [4:0]  chH;
  logic        out_vld;
  logic [7:0]  VIL;
  logic [7:0]  VIH;
  logic        thr_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  afe_thresh_cmp dut (
    .smpl_clk (clk),
    .rst_n    (rst_n),
    .VIL_PWM  (vil_pwm),
    .VIH_PWM  (vih_pwm),
    .smpl_vld (smpl_vld),
    .smpl     (smpl),
    .chL      (chL),
    .chH      (chH),
    .out_vld  (out_vld),
    .VIL      (VIL),
    .VIH      (VIH),
    .thr_err  (thr_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1ns past the edge for drive/sample.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_vil(input int n);
    vil_pwm = 1'b1;
    tick(n);
    vil_pwm = 1'b0;
  endtask

  task automatic pulse_vih(input int n);
    vih_pwm = 1'b1;
    tick(n);
    vih_pwm = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    vil_pwm  = 1'b0;
    vih_pwm  = 1'b0;
    smpl_vld = 1'b0;
    smpl     = '0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Reset state
    chk("rst_vil",     32'(VIL),     32'h55);
    chk("rst_vih",     32'(VIH),     32'hAA);
    chk("rst_chl",     32'(chL),     32'h0);
    chk("rst_chh",     32'(chH),     32'h0);
    chk("rst_out_vld", 32'(out_vld), 32'h0);
    chk("rst_thr_err", 32'(thr_err), 32'h0);

    // Reset thresholds, boundary samples: ch4..ch0 = AB AA 54 55 60
    smpl     = {8'hAB, 8'hAA, 8'h54, 8'h55, 8'h60};
    smpl_vld = 1'b1;
    tick(1);
    chk("cmp0_chl", 32'(chL),     32'b11011);
    chk("cmp0_chh", 32'(chH),     32'b10000);
    chk("cmp0_vld", 32'(out_vld), 32'h1);
    smpl_vld = 1'b0;
    smpl     = {5{8'hFF}};
    tick(1);
    chk("hold_vld", 32'(out_vld), 32'h0);
    chk("hold_chl", 32'(chL),     32'b11011);
    chk("hold_chh", 32'(chH),     32'b10000);

    // Sample coincides with VIL 0x55 -> 0x80 update (512 cycles)
    pulse_vil(512);
    tick(2);
    chk("upd_pre_vil", 32'(VIL), 32'h55);
    smpl     = 40'h60;
    smpl_vld = 1'b1;
    tick(1);
    chk("upd_vil",     32'(VIL),    32'h80);
    chk("upd_old_chl", 32'(chL[0]), 32'h1);
    tick(1);
    chk("upd_new_chl", 32'(chL[0]), 32'h0);
    smpl_vld = 1'b0;
    tick(5);

    // Single-cycle pulse captures cnt = 1 -> threshold 0
    pulse_vil(1);
    tick(3);
    chk("one_cyc_vil", 32'(VIL), 32'h00);
    tick(5);

    // 341 cycles -> 0x55
    pulse_vil(341);
    tick(3);
    chk("vil_341", 32'(VIL), 32'h55);
    tick(5);

    // 1500 cycles high: counter saturates, VIH full scale
    vih_pwm = 1'b1;
    tick(1500);
    chk("cnt_sat", 32'(dut.u_vih.cnt), 32'h3FF);
    vih_pwm = 1'b0;
    tick(3);
    chk("vih_sat", 32'(VIH), 32'hFF);
    tick(5);

    // VIL 800 -> 0xC8, VIH 400 -> 0x64, threshold inversion
    pulse_vil(800);
    tick(3);
    chk("vil_800",      32'(VIL),     32'hC8);
    chk("no_err_yet",   32'(thr_err), 32'h0);
    tick(5);
    pulse_vih(400);
    tick(3);
    chk("vih_400",      32'(VIH),     32'h64);
    chk("err_not_yet",  32'(thr_err), 32'h0);
    tick(1);
    chk("thr_err",      32'(thr_err), 32'h1);
    smpl     = 40'h70;
    smpl_vld = 1'b1;
    tick(1);
    chk("err_cmp_chl",  32'(chL),     32'b00000);
    chk("err_cmp_chh",  32'(chH),     32'b00001);
    smpl_vld = 1'b0;
    tick(5);

    // Reset in the middle of a VIH high pulse
    vih_pwm = 1'b1;
    tick(200);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("mid_rst_vih",  32'(VIH),     32'hAA);
    chk("mid_rst_vil",  32'(VIL),     32'h55);
    chk("mid_rst_err",  32'(thr_err), 32'h0);
    chk("mid_rst_chh",  32'(chH),     32'h0);
    tick(50);
    vih_pwm = 1'b0;
    tick(10);
    chk("partial_vih",  32'(VIH),     32'hAA);
    pulse_vih(100);
    tick(3);
    chk("restart_vih",  32'(VIH),     32'h19);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
